// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART slave on the MMU IO port: DATA/STATUS/DIV registers,
// one TX shifter, one RX deserializer and an RX-ready interrupt.
module io_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_txd;

    state_t        r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_s1, r_rx_s2;

    logic [7:0]    r_rx_data;
    logic          r_rx_valid, r_rx_overrun, r_rx_frame_err, r_tx_drop;

    logic [5:0]    w_sel;
    logic          w_rd_data, w_wr_data, w_wr_stat, w_tx_busy;
    logic          w_rx_done, w_rx_ferr, w_drop;

    assign w_sel     = io_addr[7:2];
    assign w_rd_data = io_en & ~io_we & (w_sel == 6'd0);
    assign w_wr_data = io_en &  io_we & (w_sel == 6'd0);
    assign w_wr_stat = io_en &  io_we & (w_sel == 6'd1);
    assign w_tx_busy = (r_tx_state != S_IDLE);
    assign w_drop    = w_wr_data & w_tx_busy;
    assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == C_LAST) &&  r_rx_s2;
    assign w_rx_ferr = (r_rx_state == S_STOP) && (r_rx_cnt == C_LAST) && !r_rx_s2;

    assign uart_txd = r_txd;
    assign irq      = r_rx_valid;

    // TX line is registered so it changes only on clock edges (and on reset).
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: if (w_wr_data) begin
                    r_tx_state <= S_START;
                    r_tx_shift <= io_data_write[7:0];
                    r_tx_cnt   <= '0;
                    r_txd      <= 1'b0;
                end
                S_START: if (r_tx_cnt == C_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= '0;
                    r_tx_state <= S_DATA;
                    r_txd      <= r_tx_shift[0];
                end else r_tx_cnt <= r_tx_cnt + CW'(1);
                S_DATA: if (r_tx_cnt == C_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bit == 3'd7) begin
                        r_tx_state <= S_STOP;
                        r_txd      <= 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_txd      <= r_tx_shift[1];
                    end
                end else r_tx_cnt <= r_tx_cnt + CW'(1);
                S_STOP: if (r_tx_cnt == C_LAST) begin
                    r_tx_cnt   <= '0;
                    r_tx_state <= S_IDLE;
                end else r_tx_cnt <= r_tx_cnt + CW'(1);
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // STOP exits at its sample point so a following start bit is not missed.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                S_IDLE: if (!r_rx_s2) begin
                    r_rx_state <= S_START;
                    r_rx_cnt   <= '0;
                end
                S_START: if (r_rx_cnt == C_HALF) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                S_DATA: if (r_rx_cnt == C_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                    else                  r_rx_bit   <= r_rx_bit + 3'd1;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                S_STOP: if (r_rx_cnt == C_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= S_IDLE;
                end else r_rx_cnt <= r_rx_cnt + CW'(1);
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // Hardware sets take priority over read-clear and write-1-to-clear.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_tx_drop      <= 1'b0;
        end else begin
            if (w_rx_done) r_rx_data <= r_rx_shift;
            r_rx_valid     <= w_rx_done | (r_rx_valid & ~w_rd_data);
            r_rx_overrun   <= (w_rx_done & r_rx_valid & ~w_rd_data) |
                              (r_rx_overrun & ~(w_wr_stat & io_data_write[2]));
            r_rx_frame_err <= w_rx_ferr | (r_rx_frame_err & ~(w_wr_stat & io_data_write[3]));
            r_tx_drop      <= w_drop | (r_tx_drop & ~(w_wr_stat & io_data_write[4]));
        end
    end

    always_comb begin
        io_data_read = '0;
        case (w_sel)
            6'd0:    io_data_read = {24'b0, r_rx_data};
            6'd1:    io_data_read = {27'b0, r_tx_drop, r_rx_frame_err, r_rx_overrun,
                                     r_rx_valid, w_tx_busy};
            6'd2:    io_data_read = 32'(CLKS_PER_BIT);
            default: io_data_read = '0;
        endcase
    end
endmodule

// File: doc/io_uart.md
# io_uart

Memory-mapped 8N1 UART peripheral on the MMU's IO port (`io_addr`/`io_en`/`io_we`/`io_data_write`/`io_data_read`). It replaces the flat IO memory model that benches currently hang on that port, giving firmware a serial console and an RX-ready interrupt. The block is a bus slave only: register reads are combinational, and register writes and read side-effects take effect on the rising clock edge.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Minimum value is 4.
- `clk` input 1: system clock, shared with the core and MMU.
- `resetb` input 1: asynchronous, active-low reset.
- `io_addr` input 8: byte address of the access. Bits [7:2] select the register; bits [1:0] are ignored.
- `io_en` input 1: access strobe, valid for one cycle.
- `io_we` input 1: 1 = write, 0 = read. Qualified by `io_en`.
- `io_data_write` input 32: write data.
- `io_data_read` output 32: combinational read data for `io_addr`.
- `uart_rxd` input 1: serial input, asynchronous to `clk`.
- `uart_txd` output 1: serial output.
- `irq` output 1: equals STATUS.rx_valid.

## Operation
- Register map (word offset):
  - 0x00 DATA.
    - Read returns {24'b0, rx_data}.
    - A read strobe (`io_en & ~io_we`) clears rx_valid at the clock edge.
    - A write loads `io_data_write[7:0]` into the TX shifter if TX is IDLE. If TX is not IDLE, the write is dropped and tx_drop is set.
  - 0x04 STATUS.
    - Read layout: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 rx_frame_err, bit4 tx_drop. Bits [31:5] read 0.
    - Writing 1 to bits 2, 3 or 4 clears that flag. All other bits ignore writes.
  - 0x08 DIV: read-only, returns CLKS_PER_BIT.
  - Any other offset reads 0; writes are ignored.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state holds for CLKS_PER_BIT cycles; DATA holds for 8×CLKS_PER_BIT cycles, one bit per period, LSB first.
  - `uart_txd` drives 0 in START, the data bit in DATA, and 1 in STOP and IDLE.
  - tx_busy = (state != IDLE).
- RX path:
  - `uart_rxd` passes through a 2-flop synchronizer, reset value 1.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: sample at CLKS_PER_BIT/2 cycles. If the sample is 1 (glitch), return to IDLE with no flags changed. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample after a further CLKS_PER_BIT cycles.
    - Sample = 1: load rx_data. If rx_valid was already 1, set rx_overrun. Set rx_valid.
    - Sample = 0: set rx_frame_err; rx_data and rx_valid are unchanged.
    - In both cases return to IDLE immediately (mid-stop-bit), so back-to-back frames are accepted.
- Simultaneous events:
  - DATA read-clear and a new byte completing in the same cycle: new byte stored, rx_valid stays 1, no overrun.
  - W1C on a flag and a hardware set of the same flag in the same cycle: set wins.
  - DATA write in the same cycle TX leaves STOP for IDLE: the write is dropped (TX is not yet IDLE at that edge).

## Timing
- Reset values: `uart_txd`=1, `irq`=0, rx_data=0, all flags 0, both FSMs IDLE, all counters 0.
- Reset asserted mid-frame aborts both FSMs immediately. `uart_txd` returns to 1 asynchronously.
- `io_data_read` has zero latency: it is a combinational function of `io_addr` and the current register state.
- TX latency: for a DATA write at edge N, `uart_txd` falls after edge N. The frame lasts exactly 10×CLKS_PER_BIT cycles, and tx_busy reads 0 in the cycle after STOP ends.
- RX latency: rx_valid rises 2 (synchronizer) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after the falling start edge on `uart_rxd`, with ±1 cycle of synchronizer uncertainty.
- Counters: bit counter is 3 bits; the baud counter is sized as clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT−1.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Reset then read each register: 0x04 -> 0, 0x08 -> 16, 0x0C -> 0; `uart_txd`=1; `irq`=0.
- Write 0xA5 to 0x00:
  - `uart_txd` shows start bit, then 1,0,1,0,0,1,0,1, then stop bit, each 16 cycles wide, 160 cycles total.
  - STATUS reads 0x01 during the frame and 0x00 after it.
- Second DATA write (0x3C) during the 0xA5 frame: the 0x3C write is dropped and STATUS reads 0x11. Writing 0x10 to 0x04 clears tx_drop.
- Loopback (`uart_txd` -> `uart_rxd`), send 0x5A:
  - `irq` rises and DATA reads 0x5A.
  - After that read strobe, `irq`=0.
- Drive two RX frames 0x11 then 0x22 with no read in between: DATA=0x22, STATUS=0x06. A 4-cycle low glitch on `uart_rxd` sets no flags.
- Drive a frame with stop bit 0: rx_frame_err=1, rx_valid unchanged. Assert `resetb` mid-frame: all flags return to 0 and `uart_txd`=1.
